// File: rtl/melody_sequencer.sv
// ============================================================================
// Module      : melody_sequencer
// Description : Steps through a parameterised song table, presenting each
//               note code and tone half-period for a fixed duration and gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_sequencer #(
    parameter int          BEAT_TICKS = 10000000,
    parameter int          GAP_TICKS  = 400000,
    parameter logic [95:0] SONG       = {{8{6'b111100}},
                                         6'd32, 6'd28, 6'd24, 6'd20,
                                         6'd16, 6'd12, 6'd8,  6'd4}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_pulse,
    input  logic        stop_pulse,
    input  logic        loop_en,
    input  logic [1:0]  tempo_sel,
    output logic [3:0]  note_code,
    output logic [16:0] note_div,
    output logic        note_valid,
    output logic        busy,
    output logic [3:0]  step_idx,
    output logic        done_pulse
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_load = 2'd1;
    localparam logic [1:0]  c_st_note = 2'd2;
    localparam logic [1:0]  c_st_gap  = 2'd3;

    localparam logic [3:0]  c_end_mark = 4'hF;
    localparam logic [3:0]  c_last_step = 4'hF;

    localparam logic [26:0] c_beat_t0  = 27'(BEAT_TICKS);
    localparam logic [26:0] c_beat_t1  = 27'(BEAT_TICKS >> 1);
    localparam logic [26:0] c_beat_t2  = 27'(BEAT_TICKS >> 2);
    localparam logic [26:0] c_gap_last = 27'(GAP_TICKS - 1);

    localparam logic [16:0] c_div_do = 17'd76336;
    localparam logic [16:0] c_div_re = 17'd68027;
    localparam logic [16:0] c_div_mi = 17'd60606;
    localparam logic [16:0] c_div_fa = 17'd57307;
    localparam logic [16:0] c_div_so = 17'd51020;
    localparam logic [16:0] c_div_la = 17'd45455;
    localparam logic [16:0] c_div_si = 17'd40486;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [3:0]  r_step;
    logic [26:0] r_cnt;
    logic [3:0]  r_note_code;
    logic [16:0] r_note_div;
    logic        r_done;

    logic [6:0]  w_bit_base;
    logic [5:0]  w_entry;
    logic [3:0]  w_note;
    logic [1:0]  w_dur;
    logic [26:0] w_beat;
    logic [26:0] w_dur_ticks;
    logic        w_song_end;
    logic        w_done;

    // High octave is the same tone at twice the frequency, so half the period.
    function automatic logic [16:0] f_div(input logic [3:0] code);
        logic [16:0] v;
        case (code)
            4'd1:    v = c_div_do;
            4'd2:    v = c_div_re;
            4'd3:    v = c_div_mi;
            4'd4:    v = c_div_fa;
            4'd5:    v = c_div_so;
            4'd6:    v = c_div_la;
            4'd7:    v = c_div_si;
            4'd8:    v = c_div_do >> 1;
            4'd9:    v = c_div_re >> 1;
            4'd10:   v = c_div_mi >> 1;
            4'd11:   v = c_div_fa >> 1;
            4'd12:   v = c_div_so >> 1;
            4'd13:   v = c_div_la >> 1;
            4'd14:   v = c_div_si >> 1;
            default: v = 17'd0;
        endcase
        return v;
    endfunction

    assign w_bit_base = {3'b000, r_step} * 7'd6;
    assign w_entry    = SONG[w_bit_base +: 6];
    assign w_note     = w_entry[5:2];
    assign w_dur      = w_entry[1:0];

    always_comb begin
        case (tempo_sel)
            2'd0:    w_beat = c_beat_t0;
            2'd1:    w_beat = c_beat_t1;
            default: w_beat = c_beat_t2;
        endcase
    end

    assign w_dur_ticks = w_beat * {25'd0, w_dur} + w_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_song_end = 1'b0;
        case (r_state)
            c_st_idle: if (play_pulse) w_next = c_st_load;
            c_st_load: begin
                if (w_note == c_end_mark) w_song_end = 1'b1;
                else                      w_next = c_st_note;
            end
            c_st_note: if (r_cnt == 27'd0) w_next = c_st_gap;
            c_st_gap: begin
                if (r_cnt == 27'd0) begin
                    if (r_step == c_last_step) w_song_end = 1'b1;
                    else                       w_next = c_st_load;
                end
            end
            default:   w_next = c_st_idle;
        endcase
        if (w_song_end) w_next = loop_en ? c_st_load : c_st_idle;
        // Stop outranks play; play from any state restarts at step 0.
        if (stop_pulse)      w_next = c_st_idle;
        else if (play_pulse) w_next = c_st_load;
    end

    assign w_done = w_song_end & ~loop_en & ~stop_pulse & ~play_pulse;

    always_comb begin
        busy       = (r_state != c_st_idle);
        note_valid = (r_note_code != 4'd0);
    end

    assign note_code  = r_note_code;
    assign note_div   = r_note_div;
    assign step_idx   = r_step;
    assign done_pulse = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step      <= 4'd0;
            r_cnt       <= 27'd0;
            r_note_code <= 4'd0;
            r_note_div  <= 17'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done;
            if (stop_pulse || play_pulse) begin
                r_step      <= 4'd0;
                r_cnt       <= 27'd0;
                r_note_code <= 4'd0;
                r_note_div  <= 17'd0;
            end else begin
                case (r_state)
                    c_st_load: begin
                        if (w_note == c_end_mark) begin
                            r_step <= 4'd0;
                        end else begin
                            r_note_code <= w_note;
                            r_note_div  <= f_div(w_note);
                            r_cnt       <= w_dur_ticks - 27'd1;
                        end
                    end
                    c_st_note: begin
                        if (r_cnt == 27'd0) begin
                            r_note_code <= 4'd0;
                            r_cnt       <= c_gap_last;
                        end else begin
                            r_cnt <= r_cnt - 27'd1;
                        end
                    end
                    c_st_gap: begin
                        if (r_cnt == 27'd0) begin
                            r_step <= (r_step == c_last_step) ? 4'd0 : r_step + 4'd1;
                        end else begin
                            r_cnt <= r_cnt - 27'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Self-checking bench for melody_sequencer against a song-level
//               reference model (default song and a custom song instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_melody_sequencer;

    localparam int C_BEAT = 4;
    localparam int C_GAP  = 2;
    localparam logic [95:0] C_CUSTOM = {
        6'd52, 6'd19, 6'd41, 6'd54, 6'd44, 6'd9, 6'd35, 6'd6,
        6'd20, 6'd50, 6'd5, 6'd0, 6'd31, 6'd56, 6'd14, 6'd3, 6'd37, 6'd3};

    typedef struct packed {
        logic        busy;
        logic [3:0]  code;
        logic [16:0] div;
        logic        valid;
        logic [3:0]  step;
        logic        done;
    } obs_t;

    typedef struct packed {
        obs_t       exp;
        logic       chk_div;
        logic       chk_step;
        logic [1:0] tsel;
    } trace_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_pulse = 1'b0;
    logic        stop_pulse = 1'b0;
    logic        loop_en = 1'b0;
    logic [1:0]  tempo_sel = 2'd0;

    logic [3:0]  code_a, code_b, step_a, step_b;
    logic [16:0] div_a, div_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    int          n_checks = 0;
    int          n_fail = 0;
    trace_t      trace_q[$];
    logic [1:0]  step_tsel[16];
    logic [95:0] songs[2];

    always #5 clk = ~clk;

    melody_sequencer #(.BEAT_TICKS(C_BEAT), .GAP_TICKS(C_GAP)) dut_a (
        .clk(clk), .rst(rst), .play_pulse(play_pulse), .stop_pulse(stop_pulse),
        .loop_en(loop_en), .tempo_sel(tempo_sel), .note_code(code_a),
        .note_div(div_a), .note_valid(valid_a), .busy(busy_a),
        .step_idx(step_a), .done_pulse(done_a));

    // Custom song: no end marker, so the song ends after the GAP of step 15.
    melody_sequencer #(.BEAT_TICKS(C_BEAT), .GAP_TICKS(C_GAP),
                       .SONG(C_CUSTOM[95:0])) dut_b (
        .clk(clk), .rst(rst), .play_pulse(play_pulse), .stop_pulse(stop_pulse),
        .loop_en(loop_en), .tempo_sel(tempo_sel), .note_code(code_b),
        .note_div(div_b), .note_valid(valid_b), .busy(busy_b),
        .step_idx(step_b), .done_pulse(done_b));

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = busy_a; o.code = code_a; o.div = div_a;
            o.valid = valid_a; o.step = step_a; o.done = done_a;
        end else begin
            o.busy = busy_b; o.code = code_b; o.div = div_b;
            o.valid = valid_b; o.step = step_b; o.done = done_b;
        end
        return o;
    endfunction

    function automatic logic [16:0] exp_div(input int code);
        int base[7] = '{76336, 68027, 60606, 57307, 51020, 45455, 40486};
        if (code >= 1 && code <= 7)  return 17'(base[code-1]);
        if (code >= 8 && code <= 14) return 17'(base[code-8] / 2);
        return 17'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        play_pulse = 1'b1;
        tick();
        play_pulse = 1'b0;
    endtask

    task automatic stop_all();
        stop_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0;
    endtask

    function automatic trace_t mk(input logic busy, input int code, input int dv,
                                  input int step, input logic done,
                                  input logic cd, input logic cs, input logic [1:0] ts);
        trace_t t;
        t.exp.busy = busy; t.exp.code = 4'(code); t.exp.div = 17'(dv);
        t.exp.valid = (code != 0); t.exp.step = 4'(step); t.exp.done = done;
        t.chk_div = cd; t.chk_step = cs; t.tsel = ts;
        return t;
    endfunction

    // Song-level model: one LOAD cycle, duration cycles of note, GAP cycles of gap.
    task automatic build_trace(input int sel, input bit lp, input int maxlen);
        logic [95:0] sh;
        int s, note, dur, beat, d, t;
        bit ended;
        trace_q.delete();
        s = 0; ended = 0;
        while (!ended && trace_q.size() < maxlen) begin
            sh = songs[sel] >> (6 * s);
            note = int'(sh[5:2]); dur = int'(sh[1:0]);
            trace_q.push_back(mk(1, 0, 0, s, 0, 0, 1, step_tsel[s]));
            if (note != 15) begin
                t = int'(step_tsel[s]);
                beat = C_BEAT >> ((t > 2) ? 2 : t);
                d = (dur + 1) * beat;
                for (int i = 0; i < d; i++)
                    trace_q.push_back(mk(1, note, int'(exp_div(note)), s, 0, 1, 1, 2'($urandom)));
                for (int i = 0; i < C_GAP; i++)
                    trace_q.push_back(mk(1, 0, int'(exp_div(note)), s, 0, 1, 1, 2'($urandom)));
            end
            if (note == 15 || s == 15) begin
                if (lp) s = 0;
                else begin
                    trace_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'($urandom)));
                    trace_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'($urandom)));
                    ended = 1;
                end
            end else begin
                s = s + 1;
            end
        end
        while (trace_q.size() > maxlen) void'(trace_q.pop_back());
    endtask

    task automatic run_trace(input int sel, input string name, output int dones);
        obs_t a, e;
        dones = 0;
        foreach (trace_q[i]) begin
            tempo_sel = trace_q[i].tsel;
            a = sample(sel);
            e = trace_q[i].exp;
            if (a.done) dones++;
            if (!trace_q[i].chk_div)  begin a.div = '0;  e.div = '0;  end
            if (!trace_q[i].chk_step) begin a.step = '0; e.step = '0; end
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got busy=%0d code=%0d div=%0d valid=%0d step=%0d done=%0d, want busy=%0d code=%0d div=%0d valid=%0d step=%0d done=%0d",
                         name, i, a.busy, a.code, a.div, a.valid, a.step, a.done,
                         e.busy, e.code, e.div, e.valid, e.step, e.done);
            end
            tick();
        end
    endtask

    task automatic check_idle(input int sel, input string name);
        obs_t a;
        a = sample(sel);
        n_checks++;
        if (a.busy !== 1'b0 || a.valid !== 1'b0 || a.code !== 4'd0 || a.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got busy=%0d valid=%0d code=%0d done=%0d, want all 0",
                     name, a.busy, a.valid, a.code, a.done);
        end
    endtask

    task automatic test_reset();
        obs_t a;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            a = sample(s);
            n_checks++;
            if (a !== '0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got %h want 0", s, a);
            end
        end
        rst = 1'b0;
        tick();
        check_idle(0, "after_reset_idle");
    endtask

    task automatic test_first_note();
        obs_t a;
        int want_code;
        logic [16:0] want_div;
        start();
        for (int c = 1; c <= 9; c++) begin
            tempo_sel = 2'd0;
            a = sample(0);
            want_code = (c >= 2 && c <= 5) ? 1 : (c == 9 ? 2 : 0);
            want_div = (c >= 2 && c <= 7) ? 17'd76336 : (c == 9 ? 17'd68027 : a.div);
            n_checks++;
            if (a.busy !== 1'b1 || a.code !== 4'(want_code) || a.div !== want_div ||
                a.valid !== (want_code != 0)) begin
                n_fail++;
                $display("FAIL first_note cycle %0d: got busy=%0d code=%0d div=%0d valid=%0d, want busy=1 code=%0d div=%0d",
                         c, a.busy, a.code, a.div, a.valid, want_code, want_div);
            end
            tick();
        end
        stop_all();
    endtask

    task automatic test_default_song();
        int dones;
        obs_t a;
        foreach (step_tsel[i]) step_tsel[i] = 2'd0;
        loop_en = 1'b0;
        build_trace(0, 0, 1000);
        start();
        run_trace(0, "default_song", dones);
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL default_song_done_count: got %0d want 1", dones);
        end
        a = sample(0);
        n_checks++;
        if (a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL default_song_busy_after: got %0d want 0", a.busy);
        end
        stop_all();
    endtask

    task automatic test_rest_tempo2();
        int dones;
        foreach (step_tsel[i]) step_tsel[i] = 2'($urandom);
        step_tsel[0] = 2'd2;
        loop_en = 1'b0;
        build_trace(1, 0, 1000);
        start();
        run_trace(1, "custom_rest_tempo2", dones);
        stop_all();
    endtask

    task automatic test_loop();
        int dones;
        foreach (step_tsel[i]) step_tsel[i] = 2'($urandom);
        loop_en = 1'b1;
        build_trace(0, 1, 220);
        start();
        run_trace(0, "loop_song", dones);
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL loop_done_count: got %0d want 0", dones);
        end
        stop_all();
        check_idle(0, "loop_stopped");
        loop_en = 1'b0;
    endtask

    task automatic test_random_songs();
        int dones;
        bit lp;
        for (int k = 0; k < 3; k++) begin
            foreach (step_tsel[i]) step_tsel[i] = 2'($urandom);
            lp = 1'($urandom);
            loop_en = lp;
            build_trace(1, lp, 320);
            start();
            run_trace(1, "random_custom", dones);
            stop_all();
            check_idle(1, "random_stopped");
        end
        loop_en = 1'b0;
    endtask

    task automatic test_stop_play();
        int dones;
        start();
        tick(); tick();
        stop_pulse = 1'b1; play_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0; play_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_idle(0, "stop_wins");
            tick();
        end
        // Restart while busy: second play mid-song must begin from step 0.
        foreach (step_tsel[i]) step_tsel[i] = 2'($urandom);
        start();
        repeat (11) tick();
        build_trace(0, 0, 1000);
        start();
        run_trace(0, "restart_while_busy", dones);
        stop_all();
    endtask

    task automatic test_rst_async();
        obs_t a;
        foreach (step_tsel[i]) step_tsel[i] = 2'd0;
        tempo_sel = 2'd0;
        start();
        repeat (5) tick();
        a = sample(0);
        n_checks++;
        if (a.busy !== 1'b1 || a.valid !== 1'b0 || a.div !== 17'd76336) begin
            n_fail++;
            $display("FAIL in_gap_before_rst: got busy=%0d valid=%0d div=%0d want 1 0 76336",
                     a.busy, a.valid, a.div);
        end
        #2 rst = 1'b1;
        #1;
        a = sample(0);
        n_checks++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_gap_async: got %h want 0", a);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle(0, "after_rst_gap");
            tick();
        end
        start();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle(0, "after_rst_note");
            tick();
        end
    endtask

    initial begin
        songs[0] = '0;
        for (int i = 0; i < 16; i++)
            songs[0] = songs[0] | ((i < 8) ? (96'(i + 1) << (6 * i + 2))
                                           : (96'(15) << (6 * i + 2)));
        songs[1] = C_CUSTOM[95:0];
        test_reset();
        test_first_note();
        test_default_song();
        test_rest_tempo2();
        test_loop();
        test_random_songs();
        test_stop_play();
        test_rst_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter BEAT_TICKS, default 10000000: clk cycles per beat at tempo_sel=0 (0.25 s at 40 MHz).
REQ-002 Parameter GAP_TICKS, default 400000: silent clk cycles between consecutive steps.
REQ-003 Parameter SONG, 96 bits, default C-major scale Do..Si, high Do, then end marker: 16 entries of 6 bits; entry i = SONG[6i+5:6i] = {note[3:0], dur[1:0]}.
REQ-004 clk  input  1  40 MHz crystal clock, sole clock domain.
REQ-005 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 play_pulse  input  1  one-cycle start request.
REQ-007 stop_pulse  input  1  one-cycle abort request.
REQ-008 loop_en  input  1  restart from step 0 at end of song.
REQ-009 tempo_sel  input  2  beat scaling, sampled at each step load.
REQ-010 note_code  output  4  current note: 0 = rest, 1-7 = Do-Si, 8-14 = high Do-Si.
REQ-011 note_div  output  17  half-period count of the current tone, consumed by the downstream tone generator.
REQ-012 note_valid  output  1  high while a non-rest note sounds.
REQ-013 busy  output  1  high whenever not IDLE.
REQ-014 step_idx  output  4  index of the current SONG entry.
REQ-015 done_pulse  output  1  one-cycle pulse at natural song end.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, NOTE, GAP.
REQ-017 IDLE + play_pulse -> LOAD with step_idx=0; busy rises in the cycle after play_pulse.
REQ-018 LOAD SHALL last exactly one cycle: fetch entry step_idx and compute duration = (dur+1) * (BEAT_TICKS >> min(tempo_sel,2)).
REQ-019 LOAD with note=15 (end marker) SHALL end the song; LOAD -> NOTE otherwise.
REQ-020 NOTE SHALL last exactly the duration in cycles, with note_code/note_div registered and valid from its first cycle; note_valid = (note_code != 0).
REQ-021 GAP SHALL last exactly GAP_TICKS cycles with note_valid=0, note_code=0, and note_div held at its last value.
REQ-022 GAP end: step_idx < 15 -> increment step_idx, go to LOAD; step_idx = 15 -> end of song.
REQ-023 End of song: loop_en=1 -> step_idx=0, LOAD, no done_pulse; loop_en=0 -> done_pulse=1 for one cycle, go to IDLE.
REQ-024 note_div table: 1..7 = 76336, 68027, 60606, 57307, 51020, 45455, 40486; 8..14 = the same values right-shifted by 1; 0 -> 0.
REQ-025 stop_pulse in any state SHALL go to IDLE next cycle: note_valid=0, busy=0, no done_pulse.
REQ-026 stop_pulse and play_pulse in the same cycle: stop wins.
REQ-027 play_pulse while busy SHALL restart: next state LOAD with step_idx=0; counters cleared.
REQ-028 Duration/gap counters SHALL be 27 bits wide with no overflow at max parameters (4 beats x 10000000).
REQ-029 tempo_sel changes mid-note SHALL take effect only at the next LOAD.

Reset
REQ-030 rst high SHALL immediately force IDLE and zero all outputs and counters: note_code, note_div, note_valid, busy, step_idx, done_pulse.
REQ-031 rst asserted mid-NOTE SHALL abort with no done_pulse; after release, operation resumes only on a new play_pulse.

Verification (BEAT_TICKS=4, GAP_TICKS=2)
REQ-032 play_pulse at cycle 0, default SONG, tempo_sel=0 -> busy=1 at cycle 1; note_code=1, note_div=76336 for cycles 2-5; gap cycles 6-7; note_code=2 from cycle 9.
REQ-033 Full default song, loop_en=0 -> 8 notes (codes 1-7, 8; divs ending 38168), end marker at step 8; single done_pulse; busy=0 afterwards.
REQ-034 Entry {0,3}, tempo_sel=2 -> note_valid=0 for 4 cycles (4 beats x 1 tick), then GAP.
REQ-035 loop_en=1 -> step_idx returns to 0 after end marker, no done_pulse, second pass identical to first.
REQ-036 stop_pulse and play_pulse together mid-NOTE -> IDLE next cycle; rst mid-GAP -> all outputs 0 asynchronously.
